// File: rtl/pkt_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_rr_arbiter_pkg : packet-format constants and arbiter state codes |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pkt_rr_arbiter_pkg;

    localparam logic [7:0] RX_QUEUE_HDR       = 8'hFF;
    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_BODY = 2'd2
    } arb_state_e;

endpackage : pkt_rr_arbiter_pkg
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fallthrough_small_fifo : first-word-fall-through FIFO, async reset   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             nearly_full_o,
    output logic             empty_o
);
    localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem_q [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   depth_q;

    // Storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   depth_q <= depth_q + 1'b1;
                2'b01:   depth_q <= depth_q - 1'b1;
                default: depth_q <= depth_q;
            endcase
        end
    end

    assign dout_o        = mem_q[rd_ptr_q];
    assign empty_o       = (depth_q == '0);
    assign nearly_full_o = (depth_q >= (MAX_DEPTH_BITS + 1)'(MAX_DEPTH - 1));

endmodule : fallthrough_small_fifo
`default_nettype wire

// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_rr_arbiter : whole-packet round-robin mux of N buffered streams  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pkt_rr_arbiter
    import pkt_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 4,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]          in_wr,
    output logic [NUM_QUEUES-1:0]          in_rdy,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    output logic                           out_wr,
    input  logic                           out_rdy,
    output logic [NUM_QUEUES-1:0]          grant
);
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int IDX_W  = $clog2(NUM_QUEUES);

    logic [WORD_W-1:0]     fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] fifo_empty;
    logic [NUM_QUEUES-1:0] fifo_nearly_full;
    logic [NUM_QUEUES-1:0] fifo_rd;
    logic                  fifo_rst;

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [NUM_QUEUES-1:0] grant_q, grant_d;
    logic                  out_wr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;

    logic                  rd_en;
    logic [WORD_W-1:0]     sel_word;
    logic [CTRL_WIDTH-1:0] sel_ctrl;
    logic                  sel_empty;
    logic [IDX_W:0]        pick;

    // Returns {found, index}; the candidate nearest after 'last' wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_QUEUES-1:0] req,
                                               input logic [IDX_W-1:0]      last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int off = NUM_QUEUES; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % NUM_QUEUES);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign fifo_rst = ~reset;

    generate
        for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
            fallthrough_small_fifo #(
                .WIDTH          (WORD_W),
                .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
            ) u_fifo (
                .clk           (clk),
                .rst           (fifo_rst),
                .din_i         ({in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH],
                                 in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
                .wr_en_i       (in_wr[g]),
                .rd_en_i       (fifo_rd[g]),
                .dout_o        (fifo_dout[g]),
                .nearly_full_o (fifo_nearly_full[g]),
                .empty_o       (fifo_empty[g])
            );
        end
    endgenerate

    assign sel_word  = fifo_dout[idx_q];
    assign sel_ctrl  = sel_word[DATA_WIDTH +: CTRL_WIDTH];
    assign sel_empty = fifo_empty[idx_q];
    assign pick      = rr_pick(~fifo_empty, last_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        grant_d = grant_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick[IDX_W]) begin
                    idx_d          = pick[IDX_W-1:0];
                    grant_d        = '0;
                    grant_d[pick[IDX_W-1:0]] = 1'b1;
                    state_d        = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (out_rdy && !sel_empty) begin
                    rd_en = 1'b1;
                    if (sel_ctrl == '0) begin
                        state_d = SEND_BODY;
                    end
                end
            end
            SEND_BODY: begin
                // A non-zero ctrl word in the body is the EOP byte mask.
                if (out_rdy && !sel_empty) begin
                    rd_en = 1'b1;
                    if (sel_ctrl != '0) begin
                        last_d  = idx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign fifo_rd = grant_q & {NUM_QUEUES{rd_en}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_QUEUES - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
        end else begin
            out_wr_q <= rd_en;
            if (rd_en) begin
                out_data_q <= sel_word[DATA_WIDTH-1:0];
                out_ctrl_q <= sel_ctrl;
            end
        end
    end

    assign in_rdy   = ~fifo_nearly_full;
    assign out_wr   = out_wr_q;
    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign grant    = grant_q;

endmodule : pkt_rr_arbiter
`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pkt_rr_arbiter : directed self-checking bench for pkt_rr_arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pkt_rr_arbiter;
    import pkt_rr_arbiter_pkg::*;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int WW = DW + CW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NQ*DW-1:0]  in_data;
    logic [NQ*CW-1:0]  in_ctrl;
    logic [NQ-1:0]     in_wr;
    logic [NQ-1:0]     in_rdy;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy;
    logic [NQ-1:0]     grant;

    int errors = 0;
    int checks = 0;

    logic [WW-1:0] src [NQ][$];
    logic [WW-1:0] exp_w[$];
    logic [WW-1:0] cap_w[$];
    int            cap_c[$];
    logic [NQ-1:0] glog[$];
    logic [NQ-1:0] gprev = '0;
    logic          rdy_e = 1'b1;
    int            cyc = 0;
    int            viol = 0;

    pkt_rr_arbiter #(
        .DATA_WIDTH      (DW),
        .CTRL_WIDTH      (CW),
        .NUM_QUEUES      (NQ),
        .FIFO_DEPTH_BITS (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    // Output/grant observer, sampled mid-cycle.
    always @(posedge clk) rdy_e = out_rdy;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (out_wr) begin
            cap_w.push_back({out_ctrl, out_data});
            cap_c.push_back(cyc);
            if (!rdy_e) viol = viol + 1;
        end
        if (grant != '0 && gprev == '0) glog.push_back(grant);
        gprev = grant;
    end

    function automatic logic [WW-1:0] pw(input int q, input int p, input int k, input int nbody);
        logic [7:0] c;
        if (k == 0) c = RX_QUEUE_HDR;
        else if (k == nbody + 1) c = 8'h0F;
        else c = 8'h00;
        return {c, 8'(q), 8'(p), 8'(k), 40'h00C0FFEE00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int q, input logic [WW-1:0] wd);
        in_wr[q]              = 1'b1;
        in_data[q*DW +: DW]   = wd[DW-1:0];
        in_ctrl[q*CW +: CW]   = wd[WW-1:DW];
    endtask

    task automatic add_pkt(input int q, input int p, input int nbody);
        for (int k = 0; k < nbody + 2; k++) src[q].push_back(pw(q, p, k, nbody));
    endtask

    task automatic add_exp(input int q, input int p, input int nbody);
        for (int k = 0; k < nbody + 2; k++) exp_w.push_back(pw(q, p, k, nbody));
    endtask

    task automatic clear_logs();
        cap_w.delete(); cap_c.delete(); glog.delete(); exp_w.delete();
        for (int q = 0; q < NQ; q++) src[q].delete();
        viol = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_wr = '0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic run_feed(input int budget, output bit ok);
        int n;
        bit busy;
        logic [WW-1:0] wd;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            for (int q = 0; q < NQ; q++) begin
                if (src[q].size() > 0 && in_rdy[q]) begin
                    wd = src[q].pop_front();
                    put(q, wd);
                end else begin
                    in_wr[q] = 1'b0;
                end
            end
            step();
            n++;
            busy = 1'b0;
            for (int q = 0; q < NQ; q++) if (src[q].size() > 0) busy = 1'b1;
        end
        in_wr = '0;
        ok = !busy;
    endtask

    task automatic wait_cap(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (cap_w.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (cap_w.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_wr = '0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
        step(); step();
        checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr: got %b want 0", out_wr); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (in_rdy !== 4'b1111) begin errors++; $display("FAIL reset_in_rdy: got %b want 1111", in_rdy); end
        checks++; if ({out_ctrl, out_data} !== '0) begin errors++; $display("FAIL reset_out_word: got %h want 0", {out_ctrl, out_data}); end
        reset = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic test_single_packet();
        bit ok;
        logic [WW-1:0] w0;
        do_reset();
        add_exp(2, 0, 3);
        w0 = pw(2, 0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            put(2, pw(2, 0, k, 3));
            step();
            if (k == 1) begin
                checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
                checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL single_early_wr: got %b want 0", out_wr); end
            end
            if (k == 2) begin
                checks++; if (out_wr !== 1'b1) begin errors++; $display("FAIL single_latency: out_wr got %b want 1", out_wr); end
                checks++; if ({out_ctrl, out_data} !== w0) begin errors++; $display("FAIL single_first_word: got %h want %h", {out_ctrl, out_data}, w0); end
            end
        end
        in_wr = '0;
        wait_cap(5, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d words want 5", cap_w.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (cap_w[i] !== exp_w[i]) begin errors++; $display("FAIL single_word%0d: got %h want %h", i, cap_w[i], exp_w[i]); end
            checks++; if (cap_c[i] - cap_c[0] !== i) begin errors++; $display("FAIL single_contig%0d: got offset %0d want %0d", i, cap_c[i] - cap_c[0], i); end
        end
        step(); step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_release: got %b want 0000", grant); end
        checks++; if (cap_w.size() !== 5) begin errors++; $display("FAIL single_count: got %0d want 5", cap_w.size()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [NQ-1:0] eg [3];
        do_reset();
        eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b1000;
        add_pkt(0, 1, 2); add_pkt(1, 1, 2); add_pkt(3, 1, 2);
        add_exp(0, 1, 2); add_exp(1, 1, 2); add_exp(3, 1, 2);
        run_feed(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_feed_timeout: got stalled want drained"); end
        wait_cap(12, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d words want 12", cap_w.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (cap_w[i] !== exp_w[i]) begin errors++; $display("FAIL rr_word%0d: got %h want %h", i, cap_w[i], exp_w[i]); end
        end
        for (int i = 1; i < 12; i++) begin
            checks++;
            if (cap_c[i] - cap_c[i-1] !== ((i % 4 == 0) ? 2 : 1)) begin
                errors++; $display("FAIL rr_gap%0d: got %0d want %0d", i, cap_c[i] - cap_c[i-1], (i % 4 == 0) ? 2 : 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (glog[i] !== eg[i]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, glog[i], eg[i]); end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        logic [WW-1:0] wd;
        logic [NQ-1:0] eg [5];
        do_reset();
        eg[0] = 4'b0010; eg[1] = 4'b0001; eg[2] = 4'b0010; eg[3] = 4'b0001; eg[4] = 4'b0010;
        for (int p = 0; p < 3; p++) add_pkt(1, p, 1);
        wd = src[1].pop_front();
        put(1, wd);
        step();
        for (int p = 0; p < 2; p++) add_pkt(0, p, 1);
        add_exp(1, 0, 1); add_exp(0, 0, 1); add_exp(1, 1, 1); add_exp(0, 1, 1); add_exp(1, 2, 1);
        run_feed(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_feed_timeout: got stalled want drained"); end
        wait_cap(15, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_timeout: got %0d words want 15", cap_w.size()); end
        checks++; if (glog.size() !== 5) begin errors++; $display("FAIL fair_grant_count: got %0d want 5", glog.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (glog[i] !== eg[i]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", i, glog[i], eg[i]); end
        end
        for (int i = 0; i < 15; i++) begin
            checks++; if (cap_w[i] !== exp_w[i]) begin errors++; $display("FAIL fair_word%0d: got %h want %h", i, cap_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [NQ-1:0] rdy_pat;
        do_reset();
        out_rdy = 1'b0;
        add_exp(0, 0, 5);
        for (int k = 0; k < 7; k++) begin
            put(0, pw(0, 0, k, 5));
            step();
            if (k == 5) begin
                checks++; if (in_rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_in_rdy6: got %b want 1", in_rdy[0]); end
            end
            if (k == 6) begin
                checks++; if (in_rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_in_rdy7: got %b want 0", in_rdy[0]); end
            end
        end
        in_wr = '0;
        step(); step();
        checks++; if (cap_w.size() !== 0) begin errors++; $display("FAIL bp_held: got %0d words want 0", cap_w.size()); end
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b want 0001", grant); end
        rdy_pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            out_rdy = rdy_pat[i];
            step();
        end
        out_rdy = 1'b1;
        wait_cap(7, 50, ok);
        step(); step();
        checks++; if (cap_w.size() !== 7) begin errors++; $display("FAIL bp_count: got %0d want 7", cap_w.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (cap_w[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, cap_w[i], exp_w[i]); end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_read_while_stalled: got %0d want 0", viol); end
        checks++; if (in_rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_in_rdy_drained: got %b want 1", in_rdy[0]); end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [NQ-1:0] eg [2];
        do_reset();
        eg[0] = 4'b0001; eg[1] = 4'b0010;
        add_exp(0, 0, 2); add_exp(1, 0, 1);
        for (int c = 0; c < 10; c++) begin
            in_wr = '0;
            case (c)
                0: put(0, pw(0, 0, 0, 2));
                1: begin put(0, pw(0, 0, 1, 2)); put(1, pw(1, 0, 0, 1)); end
                2: put(1, pw(1, 0, 1, 1));
                3: put(1, pw(1, 0, 2, 1));
                8: put(0, pw(0, 0, 2, 2));
                9: put(0, pw(0, 0, 3, 2));
                default: in_wr = '0;
            endcase
            step();
            if (c >= 4 && c <= 7) begin
                checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ur_grant_c%0d: got %b want 0001", c, grant); end
                checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL ur_no_wr_c%0d: got %b want 0", c, out_wr); end
            end
        end
        in_wr = '0;
        wait_cap(7, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ur_timeout: got %0d words want 7", cap_w.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (cap_w[i] !== exp_w[i]) begin errors++; $display("FAIL ur_word%0d: got %h want %h", i, cap_w[i], exp_w[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (glog[i] !== eg[i]) begin errors++; $display("FAIL ur_grant_order%0d: got %b want %b", i, glog[i], eg[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            put(0, pw(0, 7, k, 4));
            step();
        end
        in_wr = '0;
        for (int k = 0; k < 4; k++) step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_pre_grant: got %b want 0001", grant); end
        reset = 1'b0;
        #1;
        checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rst_async_out_wr: got %b want 0", out_wr); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_async_grant: got %b want 0000", grant); end
        checks++; if (in_rdy !== 4'b1111) begin errors++; $display("FAIL rst_async_in_rdy: got %b want 1111", in_rdy); end
        step();
        reset = 1'b1;
        step();
        clear_logs();
        add_pkt(0, 9, 2);
        add_exp(0, 9, 2);
        run_feed(20, ok);
        wait_cap(4, 40, ok);
        step(); step();
        checks++; if (cap_w.size() !== 4) begin errors++; $display("FAIL rst_post_count: got %0d want 4", cap_w.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_w[i] !== exp_w[i]) begin errors++; $display("FAIL rst_post_word%0d: got %h want %h", i, cap_w[i], exp_w[i]); end
        end
        checks++; if (glog[0] !== 4'b0001) begin errors++; $display("FAIL rst_post_grant: got %b want 0001", glog[0]); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_underrun();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pkt_rr_arbiter
`default_nettype wire

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Shares one 64-bit NetFPGA-style output datapath between NUM_QUEUES input streams, one whole packet at a time, in round-robin order.
- Each input is buffered in its own small fall-through FIFO. The arbiter never interleaves words from different packets.
- Sits between the per-port rx queues and the single-input processing stage, e.g. the port-swap/passthrough stage.

Parameters:
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl word width.
- NUM_QUEUES, 4, number of input streams (2..8).
- FIFO_DEPTH_BITS, 3, log2 depth of each input FIFO.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  NUM_QUEUES*DATA_WIDTH  flattened input data; queue i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  flattened input ctrl.
- in_wr  in  NUM_QUEUES  per-queue write strobe.
- in_rdy  out  NUM_QUEUES  per-queue ready, = !nearly_full of that FIFO.
- out_data  out  DATA_WIDTH  registered output data.
- out_ctrl  out  CTRL_WIDTH  registered output ctrl.
- out_wr  out  1  registered output write strobe.
- out_rdy  in  1  downstream ready.
- grant  out  NUM_QUEUES  one-hot owner of the output; 0 when idle.

Behaviour:
- Packet format:
  - One or more module-header words with ctrl!=0.
  - Then one or more body words with ctrl==0.
  - The last word has ctrl!=0 (byte mask) and is end of packet (EOP).
- Input side: writes go into FIFO i whenever in_wr[i]=1. Sources must respect in_rdy; a write to a full FIFO is undefined and is not checked.
- State machine, states IDLE, SEND_HDR, SEND_BODY:
  - IDLE: scan queues starting at (last+1) mod NUM_QUEUES and select the first with a non-empty FIFO. Register grant, go to SEND_HDR. No word is read in IDLE. If all FIFOs are empty, stay in IDLE with grant=0.
  - SEND_HDR: when out_rdy and the granted FIFO is non-empty, read one word. If it has ctrl==0, go to SEND_BODY.
  - SEND_BODY: when out_rdy and the granted FIFO is non-empty, read one word. If it has ctrl!=0 (EOP), set last=granted index, clear grant, go to IDLE.
- Output:
  - out_wr, out_data and out_ctrl are registered.
  - out_wr=1 in the cycle after a read; otherwise 0.
  - out_data/out_ctrl hold the last value when out_wr=0.
  - Downstream honours out_rdy with a one-word slack. The arbiter never reads while out_rdy=0.
- Latency: in_wr at cycle t to an empty, idle arbiter:
  - t+1: grant asserted.
  - t+2: first read.
  - t+3: out_wr=1.
  - Back-to-back words then stream at 1 word/cycle while out_rdy=1.
- Underrun: if the granted FIFO goes empty mid-packet, the arbiter holds state and grant and emits no words. It never switches queue until EOP.
- Fairness: after queue i's EOP, the next scan starts at i+1, wrapping from NUM_QUEUES-1 to 0. A single active queue is re-granted after one IDLE cycle.
- Simultaneous events: an in_wr to the granted FIFO in the same cycle as its read is legal, since the FIFO supports concurrent read and write.
- Reset values (asserted asynchronously, released synchronously to clk):
  - state=IDLE, last=NUM_QUEUES-1 (so queue 0 is scanned first), grant=0.
  - out_wr=0, out_data=0, out_ctrl=0.
  - All FIFOs empty.
- Reset mid-packet: the partial packet is discarded. Downstream is responsible for truncated-packet recovery.

Decomposition:
- Shared package/defines: packet-format constants (RX_QUEUE_HDR = 8'hFF, IO_QUEUE_STAGE_NUM) and state encodings for IDLE, SEND_HDR and SEND_BODY.
- Sub-module: reuse the existing fallthrough_small_fifo, one per queue via generate, WIDTH = CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS = FIFO_DEPTH_BITS. Drive its reset from !reset.
- Round-robin select: a combinational function inside pkt_rr_arbiter, not a separate module.

Test Plan:
- Single packet on queue 2 (hdr ctrl=FF, 3 body ctrl=00, last ctrl=0F), out_rdy=1 -> grant=0100 one cycle after the first write; 5 words out contiguous and unchanged, first out_wr 3 cycles after the first in_wr; grant back to 0 after EOP.
- Queues 0,1,3 each hold one 4-word packet at once -> output order 0,1,3; no interleaving; one IDLE cycle between packets.
- Queue 1 sends 3 packets while queue 0 keeps data queued -> grants alternate 1,0,1,0,1; queue 1 is never granted twice in a row while queue 0 waits.
- out_rdy toggled 1,0,0,1 during the body -> no reads while out_rdy=0; no words lost or duplicated; in_rdy[i] drops when FIFO i has 7 of 8 entries occupied.
- Underrun: queue 0 stalls 4 cycles mid-body while queue 1 is non-empty -> grant stays 0001, no out_wr; resumes on refill; queue 1 is served only after queue 0's EOP.
- Assert reset low mid-packet -> out_wr=0, grant=0, in_rdy all 1 immediately; after release, a new packet on queue 0 is forwarded correctly.
